// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {instr, pc} entries with flush.
// Define INSTR_QUEUE_BYPASS_EN to let an empty queue forward the enqueued entry combinationally.
module instr_queue #(
    parameter int DEPTH = 8,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            enq_valid,
    output logic            enq_ready,
    input  logic [31:0]     enq_instr,
    input  logic [31:0]     enq_pc,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [31:0]     deq_instr,
    output logic [31:0]     deq_pc,
    output logic [CNTW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          bypass_hit;
    logic          enq_fire;
    logic          deq_fire;
    logic          wr_en;
    logic          rd_en;

`ifdef INSTR_QUEUE_BYPASS_EN
    // Reset must win over forwarding so deq_valid is low while rst is held.
    assign bypass_hit = (count == '0) && enq_valid && !flush && !rst;
`else
    assign bypass_hit = 1'b0;
`endif

    assign enq_ready = (count != CNTW'(DEPTH));
    assign deq_valid = (count != '0) || bypass_hit;
    assign deq_instr = bypass_hit ? enq_instr : mem_instr[head];
    assign deq_pc    = bypass_hit ? enq_pc    : mem_pc[head];

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;
    // A forwarded entry consumed in the same cycle never touches storage.
    assign wr_en    = enq_fire && !(bypass_hit && deq_ready);
    assign rd_en    = deq_fire && !bypass_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) tail <= tail + PW'(1);
            if (rd_en) head <= head + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (wr_en) begin
            mem_instr[tail] <= enq_instr;
            mem_pc[tail]    <= enq_pc;
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a queue-based reference model checked every cycle.
module tb_instr_queue;
    localparam int DEPTH = 8;
    localparam int CNTW  = $clog2(DEPTH + 1);
`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            enq_valid = 1'b0;
    logic            enq_ready;
    logic [31:0]     enq_instr = '0;
    logic [31:0]     enq_pc = '0;
    logic            deq_valid;
    logic            deq_ready = 1'b0;
    logic [31:0]     deq_instr;
    logic [31:0]     deq_pc;
    logic [CNTW-1:0] count;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    logic [63:0] mq [$];
    logic [31:0] got [$];
    logic [63:0] popped;
    bit          m_bypass;
    bit          m_deq;
    bit          m_enq;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_instr(enq_instr), .enq_pc(enq_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                 input logic dr, input logic fl);
        enq_valid = ev;
        enq_instr = ei;
        enq_pc    = ep;
        deq_ready = dr;
        flush     = fl;
        #1;
        if (deq_valid && deq_ready && !flush) got.push_back(deq_pc);
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue updated from the handshake rules.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            m_bypass = BYP && mq.size() == 0 && enq_valid;
            m_deq    = deq_ready && mq.size() != 0;
            m_enq    = enq_valid && mq.size() < DEPTH && !(m_bypass && deq_ready);
            if (m_deq) popped = mq.pop_front();
            if (m_enq) mq.push_back({enq_instr, enq_pc});
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic byp_now;
            logic exp_valid;
            byp_now   = BYP && !rst && mq.size() == 0 && enq_valid && !flush;
            exp_valid = (mq.size() != 0) || byp_now;
            checkOutput("cyc_count", 32'(count), 32'(mq.size()));
            checkOutput("cyc_enq_ready", 32'(enq_ready), 32'(mq.size() != DEPTH));
            checkOutput("cyc_deq_valid", 32'(deq_valid), 32'(exp_valid));
            if (exp_valid) begin
                checkOutput("cyc_deq_pc", deq_pc, (mq.size() != 0) ? mq[0][31:0] : enq_pc);
                checkOutput("cyc_deq_instr", deq_instr, (mq.size() != 0) ? mq[0][63:32] : enq_instr);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_enq_ready", 32'(enq_ready), 1);
        checkOutput("rst_deq_valid", 32'(deq_valid), 0);
        checkOutput("rst_deq_pc", deq_pc, 0);
        rst = 1'b0;
        check_en = 1'b1;

        // Fill to full, then a refused ninth enqueue
        for (int i = 0; i < 8; i++) applyStimulus(1, 32'h1000 + i, 32'h60 + 4 * i, 0, 0);
        checkOutput("full_count", 32'(count), 8);
        checkOutput("full_enq_ready", 32'(enq_ready), 0);
        checkOutput("full_deq_pc", deq_pc, 32'h60);
        applyStimulus(1, 32'h1008, 32'h80, 0, 0);
        checkOutput("ninth_count", 32'(count), 8);

        // Full with enq and deq together: no pass-through
        applyStimulus(1, 32'h1009, 32'h84, 1, 0);
        checkOutput("fulldeq_count", 32'(count), 7);
        checkOutput("fulldeq_enq_ready", 32'(enq_ready), 1);
        checkOutput("fulldeq_deq_pc", deq_pc, 32'h64);

        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("drain_count", 32'(count), 0);

        // Interleaved traffic across the pointer wrap
        got.delete();
        for (int i = 0; i < 12; i++) applyStimulus(1, 32'h2000 + i, 32'h100 + 4 * i, 1'(i % 2), 0);
        for (int k = 0; k < 20 && deq_valid; k++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("wrap_drained", 32'(deq_valid), 0);
        checkOutput("wrap_got_size", 32'(got.size()), 12);
        for (int i = 0; i < 12 && i < got.size(); i++)
            checkOutput($sformatf("wrap_order_%0d", i), got[i], 32'h100 + 4 * i);

        // Flush with a same-cycle enqueue, held flush, then recovery
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h3000 + i, 32'h180 + 4 * i, 0, 0);
        checkOutput("preflush_count", 32'(count), 5);
        applyStimulus(1, 32'h30F0, 32'h1F0, 0, 1);
        checkOutput("flush_count", 32'(count), 0);
        checkOutput("flush_deq_valid", 32'(deq_valid), 0);
        applyStimulus(1, 32'h30F4, 32'h1F4, 0, 1);
        checkOutput("flush_held_count", 32'(count), 0);
        applyStimulus(1, 32'h3ABC, 32'h200, 0, 0);
        checkOutput("postflush_count", 32'(count), 1);
        checkOutput("postflush_deq_pc", deq_pc, 32'h200);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("postflush_drain", 32'(count), 0);

        // Empty-queue enqueue with decode ready
        enq_valid = 1; enq_instr = 32'h00500093; enq_pc = 32'h300; deq_ready = 1; flush = 0;
        #1;
        checkOutput("empty_deq_valid", 32'(deq_valid), BYP ? 1 : 0);
        if (BYP) checkOutput("bypass_instr", deq_instr, 32'h00500093);
        @(posedge clk);
        #1;
        enq_valid = 0; deq_ready = 0;
        #1;
        checkOutput("empty_next_count", 32'(count), BYP ? 0 : 1);
        checkOutput("empty_next_valid", 32'(deq_valid), BYP ? 0 : 1);
        if (!BYP) checkOutput("empty_next_instr", deq_instr, 32'h00500093);
        for (int k = 0; k < 4 && deq_valid; k++) applyStimulus(0, 0, 0, 1, 0);

        // Asynchronous reset mid-cycle with entries present
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h4000 + i, 32'h400 + 4 * i, 0, 0);
        checkOutput("prerst_count", 32'(count), 3);
        enq_valid = 0;
        #3 rst = 1;
        #1;
        checkOutput("arst_count", 32'(count), 0);
        checkOutput("arst_deq_valid", 32'(deq_valid), 0);
        checkOutput("arst_deq_instr", deq_instr, 0);
        checkOutput("arst_deq_pc", deq_pc, 0);
        #3 rst = 0;
        @(posedge clk);
        #1;
        checkOutput("postrst_count", 32'(count), 0);
        applyStimulus(1, 32'h5000, 32'h500, 0, 0);
        checkOutput("postrst_enq_count", 32'(count), 1);
        checkOutput("postrst_deq_pc", deq_pc, 32'h500);
        applyStimulus(0, 0, 0, 0, 0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, >= 2).
REQ-002 SHALL have parameter CNTW, default $clog2(DEPTH+1), occupancy counter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all entries (branch redirect).
REQ-006 SHALL have port enq_valid  input  1  fetch presents an instruction.
REQ-007 SHALL have port enq_ready  output  1  queue can accept an instruction.
REQ-008 SHALL have port enq_instr  input  32  fetched instruction word.
REQ-009 SHALL have port enq_pc  input  32  PC of enq_instr.
REQ-010 SHALL have port deq_valid  output  1  head entry valid toward decode.
REQ-011 SHALL have port deq_ready  input  1  decode consumes the head entry.
REQ-012 SHALL have port deq_instr  output  32  head instruction, the word that decode splits into opcode/funct/rd/rs/imm fields.
REQ-013 SHALL have port deq_pc  output  32  PC of head instruction.
REQ-014 SHALL have port count  output  CNTW  current occupancy, 0..DEPTH.

Function
REQ-015 SHALL be a circular FIFO of DEPTH {instr, pc} entries with head and tail pointers wrapping modulo DEPTH.
REQ-016 SHALL define enq fire = enq_valid & enq_ready & ~flush, and deq fire = deq_valid & deq_ready & ~flush.
REQ-017 SHALL drive enq_ready = (count != DEPTH), a function of registered state only, with no path from deq_ready.
REQ-018 SHALL, when full, refuse enqueue even if deq fires in the same cycle (no full pass-through).
REQ-019 SHALL, on enq fire, write the entry at tail and advance tail by 1.
REQ-020 SHALL, on deq fire, advance head by 1.
REQ-021 SHALL update count by +1 (enq only), -1 (deq only), or 0 (both or neither).
REQ-022 SHALL drive deq_valid = (count != 0), with deq_instr/deq_pc taken from the head entry (bypass case excepted, REQ-030).
REQ-023 SHALL hold deq_instr/deq_pc stable while deq_valid=1 and deq_ready=0.
REQ-024 SHALL ignore deq_ready while deq_valid=0, with no state change.
REQ-025 SHALL, on flush, set head=tail=0 and count=0 on the next edge, dropping any same-cycle enq; flush has priority over every other event.
REQ-026 SHALL, while flush is held, keep count=0; the first enq after deassertion is accepted normally.
REQ-027 SHALL have a minimum enqueue-to-deq_valid latency of 1 cycle, unless bypass is enabled.

Reset
REQ-028 SHALL, while rst=1, asynchronously force head=0, tail=0, count=0, deq_valid=0, enq_ready=1, and all storage to 0, giving deq_instr=0 and deq_pc=0.
REQ-029 SHALL, on rst asserted mid-operation, discard all entries; an enq in that cycle is lost.

Configuration
REQ-030 SHALL, when macro INSTR_QUEUE_BYPASS_EN is defined, behave as follows when count==0, enq_valid=1 and flush=0:
- deq_valid=1 and deq_instr/deq_pc = enq_instr/enq_pc combinationally in that cycle.
- If deq_ready=1: nothing is written and count stays 0.
- Otherwise: the entry is written normally.
REQ-031 SHALL, when INSTR_QUEUE_BYPASS_EN is undefined, have no combinational path from enq_* to deq_*; an empty queue gives deq_valid=0 for that cycle.

Verification
REQ-032 SHALL cover: reset, then 8 enqs (pc 0x60..0x7C) with deq_ready=0 -> count=8, enq_ready=0, deq_pc=0x60; a 9th enq is not accepted.
REQ-033 SHALL cover: full queue, enq_valid=1 and deq_ready=1 for one cycle -> count=7, enq_ready=1 next cycle, deq_pc=0x64.
REQ-034 SHALL cover: 12 enqs interleaved with deqs across the pointer wrap -> deq_pc sequence strictly in enq order, no loss or duplication.
REQ-035 SHALL cover: count=5 plus enq and flush in the same cycle -> next cycle count=0, deq_valid=0; a later enq pc=0x200 is the next dequeued entry.
REQ-036 SHALL cover: empty queue, enq instr=0x00500093 with deq_ready=1 -> with bypass, deq_valid=1 in the same cycle and count stays 0; without bypass, deq_valid=1 one cycle later.
REQ-037 SHALL cover: rst pulsed asynchronously mid-cycle with count=3 -> count=0, deq_valid=0 and deq_instr=0 immediately, without waiting for a clk edge.
